syscall_console: RTL and testbench
==================================

Name: syscall_console

Overview:
- Consumer side of the register file's `sys_call_reg` ($v0) and `std_out_address` ($a0) outputs.
- On a SYSCALL instruction it decodes $v0 and services the request:
  - streams characters to a byte console port, or
  - halts the CPU.
- Walks data memory for strings and converts integers to decimal.
- Stalls the pipeline until the service completes.

Parameters:
- MAX_STR_LEN, 256: maximum bytes emitted for print_string before abort; NUL excluded.
- ADDR_W, 32: memory address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- syscall_valid  in  1  one-cycle pulse: SYSCALL is in execute, and $v0/$a0 are valid this cycle.
- sys_call_reg  in  32  $v0 value (service code).
- std_out_address  in  32  $a0 value (argument or byte address).
- stall  out  1  freeze PC/pipeline.
- done  out  1  one-cycle pulse when a service finishes.
- halt  out  1  sticky; program exited.
- err  out  1  sticky; unsupported code or string overrun.
- mem_req  out  1  word read request.
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  read complete.
- tx_data  out  8  console byte.
- tx_valid  out  1  byte available.
- tx_ready  in  1  console accepts; transfer occurs when tx_valid & tx_ready.

Behaviour:
- Reset: state IDLE. All outputs 0: stall, done, halt, err, mem_req, mem_addr, tx_data, tx_valid. Internal counters 0.
- Reset mid-service aborts immediately; no partial byte is re-emitted after release.
- Stall rule: stall = syscall_valid | (state != IDLE) | halt, computed combinationally so the triggering cycle is frozen.
- IDLE: on syscall_valid, latch v0 = sys_call_reg and a0 = std_out_address, then dispatch on v0:
  - 1 -> INT_SIGN
  - 4 -> STR_FETCH
  - 10 -> EXIT
  - 11 -> CHAR
  - other -> set err, pulse done next cycle, return to IDLE.
- syscall_valid outside IDLE is ignored.
- CHAR: present a0[7:0] on tx_data with tx_valid high until the handshake, then DONE.
- STR_FETCH:
  - mem_req = 1, mem_addr = {addr[31:2], 2'b00}; hold until mem_ack.
  - Select the byte little-endian: addr[1:0] = 0 -> rdata[7:0] ... 3 -> rdata[31:24].
  - Byte == 0 -> DONE.
  - Else -> STR_EMIT; one fetch per byte, so unaligned starts need no special case.
  - mem_req deasserts the cycle after mem_ack.
- STR_EMIT: hold the byte until the handshake; addr += 1 (wraps at 2^32); count += 1.
  - count == MAX_STR_LEN -> set err, DONE.
  - Else -> STR_FETCH.
- INT_SIGN:
  - a0[31] = 1 -> emit '-' (0x2D), mag = -a0 as 32-bit unsigned; 0x80000000 yields 2147483648.
  - Else mag = a0.
  - Then INT_DIGIT with pow index 9 (10^9).
- INT_DIGIT: one subtraction per cycle.
  - While mag >= 10^k: mag -= 10^k, digit++.
  - Then emit ASCII '0' + digit, except leading zeros are suppressed while nothing is emitted yet and k > 0.
  - k == 0 always emits. Decrement k; after k = 0 go to DONE.
  - Worst case 9 subtractions per digit plus handshakes.
- EXIT: set halt, pulse done, go to HALTED. HALTED is absorbing until reset; stall stays 1.
- DONE: done = 1 for one cycle -> IDLE; stall drops the same cycle done is high.
- tx_valid never drops before the handshake; tx_data is stable while tx_valid is high.

Optional Feature:
- SYSCALL_READ_CHAR_EN defined:
  - Adds ports rx_data in 8, rx_valid in 1, rx_ready out 1, wb_en out 1, wb_data out 32.
  - Code 12 (read_char) waits in RX_WAIT with rx_ready = 1 until rx_valid.
  - Then pulses wb_en for one cycle with wb_data = {24'b0, rx_data}, used by the register-file write port for $v0, then DONE.
- Undefined: no such ports; code 12 is unsupported (err).

Test Plan:
- v0=11, a0=0x41, tx_ready=1 -> single byte 0x41; done 3 cycles after syscall_valid or fewer; err=0.
- v0=4, a0=0x101, memory word 0x100 = 0x00_69_48_xx -> bytes 'H','i', then done. Repeat with tx_ready toggling every other cycle -> same bytes, tx_data stable while stalled.
- v0=1, a0=0xFFFFFF33 (-205) -> '-','2','0','5'. a0=0 -> '0'. a0=0x80000000 -> "-2147483648".
- v0=10 -> halt=1, stall=1 indefinitely; later syscall_valid ignored; rst_n low clears all outputs.
- v0=99 -> no tx, err=1, done pulse.
- String of 300 non-NUL bytes -> exactly 256 bytes, then err=1. rst_n asserted mid-string -> tx_valid=0 and mem_req=0 immediately.

Source files
------------

// File: rtl/syscall_console.sv
// syscall_console: services SYSCALL requests ($v0/$a0) by streaming console bytes or halting the CPU.
// Build with `define SYSCALL_READ_CHAR_EN to add the read_char service (code 12) and its rx/wb ports.
//  state     | meaning
//  IDLE      | waiting for syscall_valid; done pulses here on return
//  CHAR      | holding a0[7:0] on the console until accepted
//  STR_FETCH | word read of the current string byte
//  STR_EMIT  | holding a string byte on the console until accepted
//  INT_SIGN  | emits '-' for negative a0, loads magnitude
//  INT_DIGIT | repeated subtraction per decimal digit, then emit
//  EXIT      | raises halt and done
//  HALTED    | absorbing until reset
//  RX_WAIT   | read_char: waiting on rx_valid (optional build)
module syscall_console #(
    parameter int MAX_STR_LEN = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              syscall_valid,
    input  logic [31:0]       sys_call_reg,
    input  logic [31:0]       std_out_address,
    output logic              stall,
    output logic              done,
    output logic              halt,
    output logic              err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
`ifdef SYSCALL_READ_CHAR_EN
    ,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wb_en,
    output logic [31:0]       wb_data
`endif
);

    localparam int CNT_W = $clog2(MAX_STR_LEN + 1);

    typedef enum logic [3:0] {
        IDLE,
        CHAR,
        STR_FETCH,
        STR_EMIT,
        INT_SIGN,
        INT_DIGIT,
        EXIT,
        HALTED,
        RX_WAIT
    } state_t;

    state_t            state;
    logic [31:0]       a0;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  count;
    logic [31:0]       mag;
    logic [3:0]        pow_idx;
    logic [3:0]        digit;
    logic              started;
    logic              last_digit;

    logic [7:0]        fetch_byte;
    logic [ADDR_W-1:0] addr_inc;
    logic [CNT_W-1:0]  count_inc;
    logic [31:0]       pow_val;

    assign stall     = syscall_valid | (state != IDLE) | halt;
    assign addr_inc  = addr + ADDR_W'(1);
    assign count_inc = count + CNT_W'(1);

    always_comb begin
        fetch_byte = mem_rdata[7:0];
        case (addr[1:0])
            2'd0: fetch_byte = mem_rdata[7:0];
            2'd1: fetch_byte = mem_rdata[15:8];
            2'd2: fetch_byte = mem_rdata[23:16];
            2'd3: fetch_byte = mem_rdata[31:24];
            default: fetch_byte = mem_rdata[7:0];
        endcase
    end

    always_comb begin
        pow_val = 32'd1;
        case (pow_idx)
            4'd0: pow_val = 32'd1;
            4'd1: pow_val = 32'd10;
            4'd2: pow_val = 32'd100;
            4'd3: pow_val = 32'd1000;
            4'd4: pow_val = 32'd10000;
            4'd5: pow_val = 32'd100000;
            4'd6: pow_val = 32'd1000000;
            4'd7: pow_val = 32'd10000000;
            4'd8: pow_val = 32'd100000000;
            4'd9: pow_val = 32'd1000000000;
            default: pow_val = 32'd1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            done       <= 1'b0;
            halt       <= 1'b0;
            err        <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            a0         <= 32'h0;
            addr       <= '0;
            count      <= '0;
            mag        <= 32'h0;
            pow_idx    <= 4'd0;
            digit      <= 4'd0;
            started    <= 1'b0;
            last_digit <= 1'b0;
`ifdef SYSCALL_READ_CHAR_EN
            rx_ready   <= 1'b0;
            wb_en      <= 1'b0;
            wb_data    <= 32'h0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SYSCALL_READ_CHAR_EN
            wb_en <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (syscall_valid) begin
                        a0 <= std_out_address;
                        case (sys_call_reg)
                            32'd1: state <= INT_SIGN;
                            32'd4: begin
                                addr     <= std_out_address[ADDR_W-1:0];
                                count    <= '0;
                                mem_req  <= 1'b1;
                                mem_addr <= {std_out_address[ADDR_W-1:2], 2'b00};
                                state    <= STR_FETCH;
                            end
                            32'd10: state <= EXIT;
                            32'd11: begin
                                tx_data  <= std_out_address[7:0];
                                tx_valid <= 1'b1;
                                state    <= CHAR;
                            end
`ifdef SYSCALL_READ_CHAR_EN
                            32'd12: begin
                                rx_ready <= 1'b1;
                                state    <= RX_WAIT;
                            end
`endif
                            default: begin
                                err  <= 1'b1;
                                done <= 1'b1;
                            end
                        endcase
                    end
                end

                CHAR: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end

                STR_FETCH: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (fetch_byte == 8'h00) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            tx_data  <= fetch_byte;
                            tx_valid <= 1'b1;
                            state    <= STR_EMIT;
                        end
                    end
                end

                STR_EMIT: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        addr     <= addr_inc;
                        count    <= count_inc;
                        if (count_inc == CNT_W'(MAX_STR_LEN)) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            mem_req  <= 1'b1;
                            mem_addr <= {addr_inc[ADDR_W-1:2], 2'b00};
                            state    <= STR_FETCH;
                        end
                    end
                end

                INT_SIGN: begin
                    pow_idx    <= 4'd9;
                    digit      <= 4'd0;
                    started    <= 1'b0;
                    last_digit <= 1'b0;
                    if (a0[31]) begin
                        // two's-complement negate; 0x80000000 stays 0x80000000 = 2147483648 unsigned
                        mag      <= -a0;
                        tx_data  <= 8'h2D;
                        tx_valid <= 1'b1;
                    end else begin
                        mag <= a0;
                    end
                    state <= INT_DIGIT;
                end

                INT_DIGIT: begin
                    if (tx_valid) begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            if (last_digit) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end else if (mag >= pow_val) begin
                        mag   <= mag - pow_val;
                        digit <= digit + 4'd1;
                    end else begin
                        digit <= 4'd0;
                        if ((digit != 4'd0) || started || (pow_idx == 4'd0)) begin
                            tx_data  <= 8'h30 + {4'h0, digit};
                            tx_valid <= 1'b1;
                            started  <= 1'b1;
                        end
                        if (pow_idx == 4'd0) begin
                            last_digit <= 1'b1;
                        end else begin
                            pow_idx <= pow_idx - 4'd1;
                        end
                    end
                end

                EXIT: begin
                    halt  <= 1'b1;
                    done  <= 1'b1;
                    state <= HALTED;
                end

                HALTED: state <= HALTED;

`ifdef SYSCALL_READ_CHAR_EN
                RX_WAIT: begin
                    if (rx_valid) begin
                        rx_ready <= 1'b0;
                        wb_en    <= 1'b1;
                        wb_data  <= {24'h0, rx_data};
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_syscall_console.sv
// Bench for syscall_console: stimulus pushes expected console bytes and done events into queues,
// a monitor pops and compares them as the DUT hands bytes over and pulses done.
module tb_syscall_console;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        syscall_valid;
    logic [31:0] sys_call_reg;
    logic [31:0] std_out_address;
    logic        stall;
    logic        done;
    logic        halt;
    logic        err;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    typedef struct packed {
        logic e;
        logic h;
    } done_t;

    logic [7:0] exp_tx[$];
    done_t      exp_done[$];
    logic [7:0] mem_b [0:4095];
    logic       toggle_mode = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;

    syscall_console #(.MAX_STR_LEN(256), .ADDR_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .syscall_valid(syscall_valid),
        .sys_call_reg(sys_call_reg),
        .std_out_address(std_out_address),
        .stall(stall),
        .done(done),
        .halt(halt),
        .err(err),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // memory model: one-cycle ack, little-endian word assembly
    initial begin
        int w;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && mem_req && !mem_ack) begin
                check("mem_addr_aligned", {30'h0, mem_addr[1:0]}, 32'h0);
                w = int'(mem_addr[11:2]) * 4;
                mem_rdata = {mem_b[w+3], mem_b[w+2], mem_b[w+1], mem_b[w]};
                mem_ack = 1'b1;
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = toggle_mode ? ~tx_ready : 1'b1;
        end
    end

    // scoreboard monitor
    initial begin
        logic       waiting;
        logic [7:0] held;
        done_t      d;
        waiting = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                waiting = 1'b0;
            end else begin
                if (waiting) begin
                    check("tx_valid_held", {31'h0, tx_valid}, 32'h1);
                    if (tx_valid) check("tx_data_stable", {24'h0, tx_data}, {24'h0, held});
                end
                if (tx_valid && tx_ready) begin
                    if (exp_tx.size() == 0) begin
                        n_checks++;
                        $display("FAIL tx_unexpected: got byte 0x%0h, expected no byte", tx_data);
                    end else begin
                        check("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
                    end
                    waiting = 1'b0;
                end else if (tx_valid) begin
                    waiting = 1'b1;
                    held = tx_data;
                end else begin
                    waiting = 1'b0;
                end
                if (done) begin
                    if (exp_done.size() == 0) begin
                        n_checks++;
                        $display("FAIL done_unexpected: got done pulse, expected none");
                    end else begin
                        d = exp_done.pop_front();
                        check("done_err", {31'h0, err}, {31'h0, d.e});
                        check("done_halt", {31'h0, halt}, {31'h0, d.h});
                        check("done_bytes_drained", exp_tx.size(), 32'h0);
                    end
                end
            end
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
    endtask

    task automatic push_done(input logic e, input logic h);
        done_t d;
        d.e = e;
        d.h = h;
        exp_done.push_back(d);
    endtask

    task automatic start_call(input logic [31:0] v0, input logic [31:0] a0);
        @(posedge clk);
        #1;
        syscall_valid = 1'b1;
        sys_call_reg = v0;
        std_out_address = a0;
        #1;
        check("stall_on_trigger", {31'h0, stall}, 32'h1);
        @(posedge clk);
        #1;
        syscall_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input logic exp_stall, output int lat);
        logic seen;
        seen = 1'b0;
        lat = 0;
        while (!seen && lat < budget) begin
            @(negedge clk);
            lat++;
            seen = done;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s_timeout: no done within %0d cycles, expected done", name, budget);
        end else begin
            check({name, "_stall_at_done"}, {31'h0, stall}, {31'h0, exp_stall});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, {31'h0, stall}, 32'h0);
        check({tag, "_done"}, {31'h0, done}, 32'h0);
        check({tag, "_halt"}, {31'h0, halt}, 32'h0);
        check({tag, "_err"}, {31'h0, err}, 32'h0);
        check({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
        check({tag, "_tx_valid"}, {31'h0, tx_valid}, 32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] a0;
        string       text;
    } int_vec_t;

    initial begin
        int       lat;
        int       pending;
        int_vec_t ivec[5];

        syscall_valid = 1'b0;
        sys_call_reg = 32'h0;
        std_out_address = 32'h0;
        for (int i = 0; i < 4096; i++) mem_b[i] = 8'h00;
        mem_b[256] = 8'h5A;
        mem_b[257] = 8'h48;
        mem_b[258] = 8'h69;
        mem_b[259] = 8'h00;
        for (int i = 0; i < 300; i++) mem_b[512 + i] = 8'h41 + 8'(i % 26);

        ivec[0] = '{32'hFFFFFF33, "-205"};
        ivec[1] = '{32'h00000000, "0"};
        ivec[2] = '{32'h80000000, "-2147483648"};
        ivec[3] = '{32'd1000000007, "1000000007"};
        ivec[4] = '{32'hFFFFFFFF, "-1"};

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        push_str("A");
        push_done(1'b0, 1'b0);
        start_call(32'd11, 32'h41);
        wait_done("char", 20, 1'b0, lat);
        check("char_latency_le3", {31'h0, (lat <= 3)}, 32'h1);

        push_str("Hi");
        push_done(1'b0, 1'b0);
        start_call(32'd4, 32'h101);
        wait_done("str", 100, 1'b0, lat);

        toggle_mode = 1'b1;
        push_str("Hi");
        push_done(1'b0, 1'b0);
        start_call(32'd4, 32'h101);
        wait_done("str_toggle", 100, 1'b0, lat);
        toggle_mode = 1'b0;

        for (int i = 0; i < 5; i++) begin
            push_str(ivec[i].text);
            push_done(1'b0, 1'b0);
            start_call(32'd1, ivec[i].a0);
            wait_done("int", 500, 1'b0, lat);
        end

        push_done(1'b1, 1'b0);
        start_call(32'd99, 32'h41);
        wait_done("bad99", 20, 1'b0, lat);
        push_done(1'b1, 1'b0);
        start_call(32'd12, 32'h41);
        wait_done("bad12", 20, 1'b0, lat);
        check("err_sticky", {31'h0, err}, 32'h1);

        do_reset("reset_after_err");
        for (int i = 0; i < 256; i++) exp_tx.push_back(8'h41 + 8'(i % 26));
        push_done(1'b1, 1'b0);
        start_call(32'd4, 32'h200);
        wait_done("overrun", 5000, 1'b0, lat);

        do_reset("reset_after_overrun");
        for (int i = 0; i < 256; i++) exp_tx.push_back(8'h41 + 8'(i % 26));
        start_call(32'd4, 32'h200);
        repeat (40) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("abort_mem_req", {31'h0, mem_req}, 32'h0);
        check("abort_stall", {31'h0, stall}, 32'h0);
        pending = exp_tx.size();
        check("abort_partial", {31'h0, (pending > 0 && pending < 256)}, 32'h1);
        exp_tx.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("after_abort_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("after_abort_mem_req", {31'h0, mem_req}, 32'h0);

        push_done(1'b0, 1'b1);
        start_call(32'd10, 32'h0);
        wait_done("exit", 20, 1'b1, lat);
        repeat (20) @(negedge clk);
        check("halted_halt", {31'h0, halt}, 32'h1);
        check("halted_stall", {31'h0, stall}, 32'h1);
        start_call(32'd11, 32'h42);
        repeat (20) @(negedge clk);
        check("halted_ignore_tx", {31'h0, tx_valid}, 32'h0);
        check("halted_still", {31'h0, halt}, 32'h1);
        do_reset("reset_after_halt");

        check("exp_tx_empty", exp_tx.size(), 32'h0);
        check("exp_done_empty", exp_done.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
